// File: rtl/sev_seg_scan_ctrl_if.sv
// Bundle of display-side signals for sev_seg_scan_ctrl.
// The master drives digit data and display controls, the slave (the scan
// controller) drives the active-low segment/anode pins and frame_sync.
// The blink_mask signal exists only when SEV_SEG_BLINK_EN is defined.
interface sev_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   en_mask;
  logic                    load;
  logic                    lz_blank;
  logic [3:0]              brightness;
`ifdef SEV_SEG_BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;
`endif
  logic [6:0]              Seg;
  logic                    DP;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    frame_sync;

  modport master (
`ifdef SEV_SEG_BLINK_EN
    output blink_mask,
`endif
    output digits_in, dp_in, en_mask, load, lz_blank, brightness,
    input  Seg, DP, AN, frame_sync
  );

  modport slave (
`ifdef SEV_SEG_BLINK_EN
    input  blink_mask,
`endif
    input  digits_in, dp_in, en_mask, load, lz_blank, brightness,
    output Seg, DP, AN, frame_sync
  );
endinterface

// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered digits,
// per-digit enable and decimal point, leading-zero blanking and 4-bit PWM
// brightness. All pin outputs are registered and active low.
// Optional blink support is compiled in with `define SEV_SEG_BLINK_EN.
module sev_seg_scan_ctrl #(
  parameter int  NUM_DIGITS  = 8,
  parameter int  REFRESH_DIV = 100000,
  localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
  input logic                clk,
  input logic                reset,
  sev_seg_scan_ctrl_if.slave bus
);

  localparam int PRESC_W = $clog2(REFRESH_DIV);

  if (REFRESH_DIV < 16 || NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : gen_param_check
    $error("sev_seg_scan_ctrl: REFRESH_DIV must be >= 16 and NUM_DIGITS in 2..16");
  end

  logic [PRESC_W-1:0]              presc_q;
  logic [IDX_W-1:0]                idx_q;
  logic [3:0]                      pwm_q;
  logic [NUM_DIGITS-1:0][3:0]      shadow_dig_q, frame_dig_q;
  logic [NUM_DIGITS-1:0]           shadow_dp_q, frame_dp_q;
  logic [NUM_DIGITS-1:0]           an_q, an_d;
  logic [6:0]                      seg_q, seg_d;
  logic                            dp_q, dp_d;
  logic                            frame_sync_q;
  logic                            tick, wrap_tick;
  logic [NUM_DIGITS-1:0]           blank;
  logic                            zero_run;
  logic                            lit;

`ifdef SEV_SEG_BLINK_EN
  logic [4:0] blink_cnt_q;
  logic       blink_phase_q;

  // Blink phase flips once every 32 frame wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (wrap_tick) begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
      if (blink_cnt_q == 5'd31) blink_phase_q <= ~blink_phase_q;
    end
  end
`endif

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot tick and frame wrap detection.
  always_comb begin
    tick      = (presc_q == PRESC_W'(REFRESH_DIV - 1));
    wrap_tick = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
  end

  // Leading-zero run scanned from the most significant digit down; digit 0 never blanks.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (frame_dig_q[k] == 4'h0);
      blank[k] = bus.lz_blank & zero_run & (k != 0);
    end
  end

  // Next pin values for the current scan slot; anodes dark on every tick to avoid ghosting.
  always_comb begin
    lit = (pwm_q < bus.brightness) && bus.en_mask[idx_q];
`ifdef SEV_SEG_BLINK_EN
    if (blink_phase_q && bus.blink_mask[idx_q]) lit = 1'b0;
`endif
    an_d = '1;
    if (!tick && lit) an_d = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = blank[idx_q] ? 7'h7F : hex_to_seg(frame_dig_q[idx_q]);
    dp_d  = ~frame_dp_q[idx_q];
  end

  // Prescaler, scan index, PWM counter and frame pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      frame_sync_q <= 1'b0;
    end else begin
      presc_q      <= tick ? '0 : presc_q + 1'b1;
      pwm_q        <= pwm_q + 1'b1;
      frame_sync_q <= wrap_tick;
      if (tick) idx_q <= wrap_tick ? '0 : idx_q + 1'b1;
    end
  end

  // Shadow captures on load; frame copies at the wrap, taking live inputs if load coincides.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      frame_dig_q  <= '0;
      frame_dp_q   <= '0;
    end else begin
      if (bus.load) begin
        shadow_dig_q <= bus.digits_in;
        shadow_dp_q  <= bus.dp_in;
      end
      if (wrap_tick) begin
        frame_dig_q <= bus.load ? bus.digits_in : shadow_dig_q;
        frame_dp_q  <= bus.load ? bus.dp_in     : shadow_dp_q;
      end
    end
  end

  // Registered pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= '1;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.Seg        = seg_q;
  assign bus.DP         = dp_q;
  assign bus.frame_sync = frame_sync_q;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Self-checking bench for sev_seg_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=16).
// The reference model derives slot, digit and PWM phase from a cycle count
// since reset and keeps the buffers as plain integers.
module tb_sev_seg_scan_ctrl;
  localparam int N     = 4;
  localparam int R     = 16;
  localparam int FRAME = N * R;
  localparam int W     = 4 * N;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sev_seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  sev_seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int           m_c;
  logic [W-1:0] m_shadow, m_frame;
  logic [N-1:0] m_shadow_dp, m_frame_dp;
  logic [N-1:0] e_an;
  logic [6:0]   e_seg;
  logic         e_dp, e_fs;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int   idx, pos;
    logic blank;
    if (reset) begin
      m_c <= 0;
      m_shadow <= '0; m_frame <= '0; m_shadow_dp <= '0; m_frame_dp <= '0;
      e_an <= '1; e_seg <= 7'h7F; e_dp <= 1'b1; e_fs <= 1'b0;
    end else begin
      pos   = m_c % R;
      idx   = (m_c / R) % N;
      blank = bus.lz_blank && (idx != 0) && ((m_frame >> (4 * idx)) == '0);
      e_an  <= (pos == R - 1 || (m_c % 16) >= int'(bus.brightness) || !bus.en_mask[idx])
               ? '1 : ~(N'(1) << idx);
      e_seg <= blank ? 7'h7F : seg_of(m_frame[4*idx +: 4]);
      e_dp  <= ~m_frame_dp[idx];
      e_fs  <= (m_c % FRAME) == FRAME - 1;
      if (bus.load) begin
        m_shadow    <= bus.digits_in;
        m_shadow_dp <= bus.dp_in;
      end
      if ((m_c % FRAME) == FRAME - 1) begin
        m_frame    <= bus.load ? bus.digits_in : m_shadow;
        m_frame_dp <= bus.load ? bus.dp_in : m_shadow_dp;
      end
      m_c <= m_c + 1;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (bus.frame_sync === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    step();
    tests++;
    if (bus.AN !== 4'hF) begin
      fails++; $display("FAIL reset_an: got %b want 1111", bus.AN);
    end
    tests++;
    if (bus.Seg !== 7'h7F) begin
      fails++; $display("FAIL reset_seg: got %h want 7f", bus.Seg);
    end
    tests++;
    if ({bus.DP, bus.frame_sync} !== 2'b10) begin
      fails++; $display("FAIL reset_dp_fs: got %b want 10", {bus.DP, bus.frame_sync});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_display;
    bit ok;
    int dark;
    bus.digits_in = 16'h12AF; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    wait_fs(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL basic_sync: got %b want 1", ok); end
    dark = 0;
    for (int k = 1; k <= FRAME; k++) begin
      step();
      if (bus.AN === 4'hF) dark++;
      tests++;
      if ({bus.AN, bus.Seg, bus.DP, bus.frame_sync} !== {e_an, e_seg, e_dp, e_fs}) begin
        fails++;
        $display("FAIL basic_model k=%0d: got %b/%h/%b/%b want %b/%h/%b/%b", k,
                 bus.AN, bus.Seg, bus.DP, bus.frame_sync, e_an, e_seg, e_dp, e_fs);
      end
      if (k == 1) begin
        tests++;
        if ({bus.AN, bus.Seg} !== {4'b1110, 7'h0E}) begin
          fails++; $display("FAIL basic_digit0: got %b/%h want 1110/0e", bus.AN, bus.Seg);
        end
      end
      if (k == 49) begin
        tests++;
        if ({bus.AN, bus.Seg} !== {4'b0111, 7'h79}) begin
          fails++; $display("FAIL basic_digit3: got %b/%h want 0111/79", bus.AN, bus.Seg);
        end
      end
    end
    tests++;
    if (dark !== 4) begin fails++; $display("FAIL basic_tick_dark: got %0d want 4", dark); end
  endtask

  task automatic test_double_buffer;
    bit ok;
    wait_fs(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL dbuf_sync: got %b want 1", ok); end
    bus.digits_in = 16'h1234; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int k = 1; k < 2 * FRAME; k++) begin
      step();
      tests++;
      if ({bus.AN, bus.Seg, bus.DP, bus.frame_sync} !== {e_an, e_seg, e_dp, e_fs}) begin
        fails++;
        $display("FAIL dbuf_model k=%0d: got %b/%h/%b/%b want %b/%h/%b/%b", k,
                 bus.AN, bus.Seg, bus.DP, bus.frame_sync, e_an, e_seg, e_dp, e_fs);
      end
      if (k == 20 || k == 84) begin
        tests++;
        if ({bus.AN, bus.Seg} !== {4'b1101, (k == 20) ? 7'h08 : 7'h30}) begin
          fails++;
          $display("FAIL dbuf_digit1 k=%0d: got %b/%h want 1101/%h", k, bus.AN, bus.Seg,
                   (k == 20) ? 7'h08 : 7'h30);
        end
      end
    end
    // Load exactly in the wrap-tick cycle.
    for (int i = 0; i < FRAME && (m_c % FRAME) != FRAME - 1; i++) step();
    bus.digits_in = 16'h7E0C; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    tests++;
    if ({bus.AN, bus.Seg} !== {4'b1110, 7'h46}) begin
      fails++; $display("FAIL wrap_load: got %b/%h want 1110/46", bus.AN, bus.Seg);
    end
  endtask

  task automatic test_lz_blank;
    bit ok;
    logic [6:0] want [2][4];
    want[0] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    want[1] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    bus.lz_blank = 1'b1;
    for (int p = 0; p < 2; p++) begin
      bus.digits_in = (p == 0) ? 16'h0050 : 16'h0000; bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      wait_fs(ok);
      tests++;
      if (ok !== 1'b1) begin fails++; $display("FAIL lz_sync: got %b want 1", ok); end
      for (int k = 1; k <= FRAME; k++) begin
        step();
        tests++;
        if ({bus.AN, bus.Seg, bus.DP, bus.frame_sync} !== {e_an, e_seg, e_dp, e_fs}) begin
          fails++;
          $display("FAIL lz_model k=%0d: got %b/%h/%b/%b want %b/%h/%b/%b", k,
                   bus.AN, bus.Seg, bus.DP, bus.frame_sync, e_an, e_seg, e_dp, e_fs);
        end
        if ((k % R) == 1) begin
          tests++;
          if (bus.Seg !== want[p][k / R]) begin
            fails++;
            $display("FAIL lz_digit p=%0d d=%0d: got %h want %h", p, k / R, bus.Seg,
                     want[p][k / R]);
          end
        end
      end
    end
    bus.lz_blank = 1'b0;
  endtask

  task automatic test_brightness;
    bit ok;
    int per_dig [N];
    int total;
    bus.brightness = 4'd4;
    for (int p = 0; p < 2; p++) begin
      wait_fs(ok);
      tests++;
      if (ok !== 1'b1) begin fails++; $display("FAIL bright_sync: got %b want 1", ok); end
      for (int d = 0; d < N; d++) per_dig[d] = 0;
      total = 0;
      for (int k = 1; k <= FRAME; k++) begin
        step();
        for (int d = 0; d < N; d++) if (bus.AN[d] === 1'b0) per_dig[d]++;
        if (bus.AN !== 4'hF) total++;
      end
      if (p == 0) begin
        for (int d = 0; d < N; d++) begin
          tests++;
          if (per_dig[d] !== 4) begin
            fails++; $display("FAIL bright4_d%0d: got %0d want 4", d, per_dig[d]);
          end
        end
      end else begin
        tests++;
        if (total !== 0) begin fails++; $display("FAIL bright0: got %0d want 0", total); end
      end
      bus.brightness = 4'd0;
    end
    bus.brightness = 4'd15;
  endtask

  task automatic test_en_mask_dp;
    bit ok;
    int an2_low, dp_low, dp_bad;
    bus.en_mask = 4'b1011; bus.dp_in = 4'b0001; bus.digits_in = 16'h89CD; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    wait_fs(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL en_sync: got %b want 1", ok); end
    an2_low = 0; dp_low = 0; dp_bad = 0;
    for (int k = 1; k <= FRAME; k++) begin
      step();
      if (bus.AN[2] === 1'b0) an2_low++;
      if (bus.DP === 1'b0) begin
        dp_low++;
        if (k > R) dp_bad++;
      end
    end
    tests++;
    if (an2_low !== 0) begin fails++; $display("FAIL en_an2: got %0d want 0", an2_low); end
    tests++;
    if (dp_low !== R || dp_bad !== 0) begin
      fails++; $display("FAIL en_dp: got %0d/%0d want %0d/0", dp_low, dp_bad, R);
    end
    bus.en_mask = '1; bus.dp_in = '0;
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      bus.en_mask    = N'($urandom);
      bus.lz_blank   = 1'($urandom);
      bus.brightness = 4'($urandom);
      for (int k = 0; k < 2 * FRAME; k++) begin
        bus.load = ($urandom_range(0, 15) == 0);
        bus.digits_in = W'($urandom);
        bus.dp_in     = N'($urandom);
        step();
        tests++;
        if ({bus.AN, bus.Seg, bus.DP, bus.frame_sync} !== {e_an, e_seg, e_dp, e_fs}) begin
          fails++;
          $display("FAIL rand_model it=%0d k=%0d: got %b/%h/%b/%b want %b/%h/%b/%b", it, k,
                   bus.AN, bus.Seg, bus.DP, bus.frame_sync, e_an, e_seg, e_dp, e_fs);
        end
      end
    end
    bus.load = 1'b0; bus.en_mask = '1; bus.lz_blank = 1'b0; bus.brightness = 4'd15;
  endtask

  task automatic test_reset_midframe;
    bit ok;
    wait_fs(ok);
    for (int i = 0; i < 30; i++) step();
    reset = 1'b1;
    step();
    tests++;
    if ({bus.AN, bus.Seg, bus.DP, bus.frame_sync} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL midreset_out: got %b/%h/%b/%b want 1111/7f/1/0",
               bus.AN, bus.Seg, bus.DP, bus.frame_sync);
    end
    reset = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      step();
      tests++;
      if ({bus.AN, bus.Seg, bus.DP, bus.frame_sync} !== {e_an, e_seg, e_dp, e_fs}) begin
        fails++;
        $display("FAIL midreset_model k=%0d: got %b/%h/%b/%b want %b/%h/%b/%b", k,
                 bus.AN, bus.Seg, bus.DP, bus.frame_sync, e_an, e_seg, e_dp, e_fs);
      end
      if (k == 1 || k == R + 1) begin
        tests++;
        if ({bus.AN, bus.Seg} !== {(k == 1) ? 4'b1110 : 4'b1101, 7'h40}) begin
          fails++; $display("FAIL midreset_scan k=%0d: got %b/%h", k, bus.AN, bus.Seg);
        end
      end
      if (k == FRAME) begin
        tests++;
        if (bus.frame_sync !== 1'b1) begin
          fails++; $display("FAIL midreset_fs: got %b want 1", bus.frame_sync);
        end
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.digits_in  = '0;
    bus.dp_in      = '0;
    bus.en_mask    = '1;
    bus.load       = 1'b0;
    bus.lz_blank   = 1'b0;
    bus.brightness = 4'd15;
`ifdef SEV_SEG_BLINK_EN
    bus.blink_mask = '0;
`endif
    test_reset();
    test_basic_display();
    test_double_buffer();
    test_lz_blank();
    test_brightness();
    test_en_mask_dp();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sev_seg_scan_ctrl.md
Name: sev_seg_scan_ctrl

Overview:
- Parametrised successor to the fixed 8-digit seven-segment controller.
- Multiplexes NUM_DIGITS hex digits onto shared active-low segment and anode lines.
- Adds the following over the fixed controller:
  - double-buffered, tear-free digit loading
  - per-digit enable mask and per-digit decimal points
  - leading-zero blanking
  - 4-bit PWM brightness control
- Sits between the CPU/datapath register outputs and the board seven-segment pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (2..16)
REFRESH_DIV, 100000, clk cycles per digit slot (>=16)
IDX_W, $clog2(NUM_DIGITS), scan index width (derived, not overridden)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
digits_in  input  4*NUM_DIGITS  hex nibbles; digit i = digits_in[4i+3:4i], digit 0 rightmost
dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit
en_mask  input  NUM_DIGITS  1 = digit may be displayed, 0 = forced dark
load  input  1  capture digits_in/dp_in into shadow buffer this cycle
lz_blank  input  1  1 = suppress leading zeros
brightness  input  4  on-time in sixteenths; 0 = dark
Seg  output  7  active-low segments, Seg[0]=a ... Seg[6]=g
DP  output  1  active-low decimal point
AN  output  NUM_DIGITS  active-low anodes, one-hot-low
frame_sync  output  1  one-cycle pulse when scan wraps to digit 0

Behaviour:
- Reset: synchronous active-high, on clk rising edge.
  - Outputs: AN all ones, Seg 7'h7F, DP 1, frame_sync 0.
  - State: prescaler 0, scan index 0, pwm counter 0, shadow and frame buffers all zero (DPs off).
- Prescaler:
  - Counts 0..REFRESH_DIV-1.
  - tick asserted in the cycle count == REFRESH_DIV-1; count then wraps to 0.
- Scan index:
  - On tick, advances by 1.
  - From NUM_DIGITS-1 it wraps to 0; frame_sync=1 in the cycle after that wrap tick (registered).
- Shadow buffer:
  - When load=1, captures digits_in and dp_in at the clock edge.
  - No other effect on the display.
- Frame buffer:
  - Copies the shadow on the wrap tick, so the display only changes at frame boundaries.
  - load and wrap tick in the same cycle: frame buffer takes digits_in/dp_in directly (load wins).
- Leading-zero blanking, evaluated combinationally on the frame buffer:
  - With lz_blank=1, digit k is blanked when its nibble and every nibble above it are 0.
  - Digit 0 is never blanked.
  - Example, NUM_DIGITS=4, 0x0050: digits 3 and 2 blank, digits 1 and 0 shown.
  - A blanked digit's DP is still shown if requested.
- PWM:
  - 4-bit counter increments every clk, free-running, wraps 15->0.
  - Current digit's anode is driven low only when pwm_cnt < brightness.
  - brightness=0 gives a dark display; 15 gives 15/16 duty.
- Anode for the current digit is off (1) if en_mask bit is 0.
- Output decode:
  - Standard hex table, active low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
  - Blanked digit gives Seg=7'h7F.
  - DP = ~frame_dp[idx].
- Latency: AN, Seg and DP are registered, 1 clk after scan index/pwm change.
- Ghosting prevention: AN is forced all ones in the cycle of every tick, so no two anodes are ever low simultaneously.
- Parameter check: REFRESH_DIV<16 or NUM_DIGITS outside 2..16 is an elaboration error.

Optional Feature:
SEV_SEG_BLINK_EN
- Defined:
  - Adds input blink_mask [NUM_DIGITS].
  - Adds a blink counter that toggles a blink phase every 32 frame wraps.
  - When the phase is 1, digits with blink_mask=1 are forced dark (AN high).
  - Blink counter and phase reset to 0.
- Undefined: port, counter and logic are absent; behaviour is identical to the base block.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=16, brightness=15, lz_blank=0; load 0x12AF with load held for 1 cycle -> after the next wrap, digit 0 shows Seg=7'h0E with AN=4'b1110, digit 3 shows Seg=7'h79 with AN=4'b0111; each slot is 16 clks with AN=4'hF in each tick cycle.
- Load 0x1234 mid-frame -> display holds the old value until frame_sync, then shows 0x1234. Load asserted in the exact wrap-tick cycle -> new value appears in that same frame.
- lz_blank=1, load 0x0050 -> digits 3 and 2 show Seg=7'h7F; digit 1 shows 7'h12; digit 0 shows 7'h40. Load 0x0000 -> only digit 0 is lit, showing 7'h40.
- brightness=4 -> within each slot, the current anode is low in exactly 4 of every 16 clks. brightness=0 -> AN stays 4'hF.
- en_mask=4'b1011 with dp_in=4'b0001 -> digit 2 anode never goes low; DP=0 only during the digit-0 slot.
- Assert reset mid-frame -> next cycle AN=4'hF, Seg=7'h7F, DP=1, frame_sync=0; scan restarts at digit 0 after 16 clks; display shows 0 (buffers cleared).
